apb_cmd_issuer: RTL and testbench

- Command-queue front end that sits directly upstream of the APB master/slave subsystem and drives its request pins: PRESETn, transfer, READ_WRITE, apb_write_paddr, apb_write_data and apb_read_paddr.
- Buffers read/write commands from a local requester in a FIFO and issues them one at a time.
- Holds each request for a fixed number of cycles, then captures apb_read_data_out and PSLVERR into a one-cycle response pulse.

---
 rtl/apb_cmd_issuer.sv | 195 +++++++++++++++++++
 tb/tb_apb_cmd_issuer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_issuer.sv
// ============================================================================
// Module      : apb_cmd_issuer
// Description : Command FIFO and issue FSM that drives the APB master request
//               pins. Each command holds transfer high for XFER_CYCLES cycles.
//               Optional halt-on-slave-error: define APB_ERR_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_issuer #(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 8,
   parameter int XFER_CYCLES = 3
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_rw,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [DATA_W-1:0]          cmd_wdata,
   output logic [$clog2(DEPTH):0]     cmd_level,
   output logic                       PRESETn,
   output logic                       transfer,
   output logic                       READ_WRITE,
   output logic [ADDR_W-1:0]          apb_write_paddr,
   output logic [DATA_W-1:0]          apb_write_data,
   output logic [ADDR_W-1:0]          apb_read_paddr,
   input  logic [DATA_W-1:0]          apb_read_data_out,
   input  logic                       PSLVERR,
   output logic                       rsp_valid,
   output logic                       rsp_rw,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   input  logic                       err_clear,
   output logic                       halted
);

   localparam int c_PTR_W   = $clog2(DEPTH);
   localparam int c_LVL_W   = c_PTR_W + 1;
   localparam int c_CNT_W   = $clog2(XFER_CYCLES + 1);
   localparam int c_ENTRY_W = 1 + ADDR_W + DATA_W;
   localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_XFER = c_CNT_W'(XFER_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_ENTRY_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic [c_LVL_W-1:0]    w_level_next;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_blocked;
   logic                  w_head_rw;
   logic [ADDR_W-1:0]     w_head_addr;
   logic [DATA_W-1:0]     w_head_wdata;

   assign w_push = cmd_valid & cmd_ready;
   assign {w_head_rw, w_head_addr, w_head_wdata} = r_mem[r_rd_ptr];

`ifdef APB_ERR_HALT_EN
   // An erroring command must already block the pop decision taken in DONE.
   assign w_blocked = halted | ((r_state == S_DONE) & rsp_err);
`else
   logic w_unused_err_clear;
   assign w_unused_err_clear = err_clear;
   assign w_blocked          = 1'b0;
   assign halted             = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((cmd_level != '0) && !w_blocked) begin
               w_state_next = S_ISSUE;
               w_pop        = 1'b1;
            end
         end
         S_ISSUE: begin
            if (r_count == c_XFER) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if ((cmd_level != '0) && !w_blocked) begin
               w_state_next = S_ISSUE;
               w_pop        = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_level_next = cmd_level;
      if (w_push && !w_pop) begin
         w_level_next = cmd_level + c_LVL_W'(1);
      end else if (!w_push && w_pop) begin
         w_level_next = cmd_level - c_LVL_W'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state         <= S_IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         cmd_level       <= '0;
         cmd_ready       <= 1'b0;
         PRESETn         <= 1'b0;
         transfer        <= 1'b0;
         READ_WRITE      <= 1'b0;
         apb_write_paddr <= '0;
         apb_write_data  <= '0;
         apb_read_paddr  <= '0;
         rsp_valid       <= 1'b0;
         rsp_rw          <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
      end else begin
         PRESETn   <= 1'b1;
         r_state   <= w_state_next;
         cmd_level <= w_level_next;
         // Readiness follows the new occupancy so a full FIFO never accepts.
         cmd_ready <= (w_level_next < c_FULL);
         transfer  <= (w_state_next == S_ISSUE);
         rsp_valid <= 1'b0;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end

         if (w_pop) begin
            r_rd_ptr        <= r_rd_ptr + c_PTR_W'(1);
            r_count         <= c_CNT_W'(1);
            READ_WRITE      <= w_head_rw;
            apb_read_paddr  <= w_head_rw ? w_head_addr : '0;
            apb_write_paddr <= w_head_rw ? '0 : w_head_addr;
            apb_write_data  <= w_head_rw ? '0 : w_head_wdata;
         end else begin
            if (r_state == S_ISSUE) begin
               r_count <= r_count + c_CNT_W'(1);
            end
            if (w_state_next == S_IDLE) begin
               READ_WRITE      <= 1'b0;
               apb_read_paddr  <= '0;
               apb_write_paddr <= '0;
               apb_write_data  <= '0;
            end
         end

         if ((r_state == S_ISSUE) && (w_state_next == S_DONE)) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= READ_WRITE;
            rsp_rdata <= READ_WRITE ? apb_read_data_out : '0;
            rsp_err   <= PSLVERR;
         end
      end
   end

`ifdef APB_ERR_HALT_EN
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         halted <= 1'b0;
      end else if ((r_state == S_DONE) && rsp_err) begin
         halted <= 1'b1;
      end else if (err_clear) begin
         halted <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_issuer.sv
// ============================================================================
// Module      : tb_apb_cmd_issuer
// Description : Scoreboard bench for apb_cmd_issuer with a simple APB master
//               model; covers halt behaviour when APB_ERR_HALT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_issuer;

   localparam int DEPTH = 8;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int XFER_CYCLES = 3;
   localparam logic [ADDR_W-1:0] c_ERR_ADDR = 9'h0EE;

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] rd;
      logic              err;
   } cmd_t;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              cmd_valid, cmd_ready, cmd_rw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        cmd_level;
   logic              PRESETn, transfer, READ_WRITE;
   logic [ADDR_W-1:0] apb_write_paddr, apb_read_paddr;
   logic [DATA_W-1:0] apb_write_data, apb_read_data_out;
   logic              PSLVERR;
   logic              rsp_valid, rsp_rw, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic              err_clear, halted;

   int   checks = 0;
   int   errors = 0;
   int   full_seen = 0;
   cmd_t exp_q[$];
   cmd_t iss_q[$];

   always #5 PCLK = ~PCLK;

   apb_cmd_issuer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .XFER_CYCLES(XFER_CYCLES)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_level(cmd_level),
      .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
      .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
      .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
      .PSLVERR(PSLVERR), .rsp_valid(rsp_valid), .rsp_rw(rsp_rw),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .err_clear(err_clear), .halted(halted)
   );

   // Master model: read data is a fixed function of the address, and one
   // address always answers with a slave error.
   assign apb_read_data_out = apb_read_paddr[7:0] ^ 8'hC3;
   assign PSLVERR = transfer &&
                    ((READ_WRITE ? apb_read_paddr : apb_write_paddr) == c_ERR_ADDR);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic push_cmd(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_t c;
      int   n = 0;
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 200) begin
         @(posedge PCLK); #1;
         n++;
      end
      if (n >= 200) check("push_timeout", 32'(cmd_ready), 32'd1);
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      c.rw   = rw;
      c.addr = a;
      c.wd   = rw ? 8'h00 : d;
      c.rd   = rw ? (a[7:0] ^ 8'hC3) : 8'h00;
      c.err  = (a == c_ERR_ADDR);
      exp_q.push_back(c);
      iss_q.push_back(c);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge PCLK); #1;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge PCLK);
      #1;
   endtask

   function automatic logic [31:0] req_vec(input cmd_t c);
      return c.rw ? {5'd0, 1'b1, c.addr, 9'd0, 8'd0} : {5'd0, 1'b0, 9'd0, c.addr, c.wd};
   endfunction

   // Monitor: request shape, transfer length, inter-command gap, responses.
   cmd_t cur;
   logic prev_tr = 1'b0;
   logic pending = 1'b0;
   logic cur_err = 1'b0;
   int   run = 0;
   int   gap = 0;

   always @(negedge PCLK) begin
      if (PRESET) begin
         prev_tr = 1'b0;
         pending = 1'b0;
         run = 0;
         gap = 0;
      end else begin
         if (cmd_level == 4'(DEPTH)) begin
            full_seen++;
            check("full_ready", 32'(cmd_ready), 32'd0);
         end
         if (transfer && !prev_tr) begin
            if (iss_q.size() == 0) begin
               check("xfer_unexp", 32'(transfer), 32'd0);
            end else begin
               cur = iss_q.pop_front();
               if (pending) check("gap", gap, 1);
            end
            run = 0;
         end
         if (transfer) begin
            run++;
            check("req", {5'd0, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data},
                  req_vec(cur));
         end
         if (!transfer && prev_tr) begin
            check("xfer_len", run, XFER_CYCLES);
            cur_err = cur.err;
`ifdef APB_ERR_HALT_EN
            pending = (iss_q.size() != 0) && !cur_err;
`else
            pending = (iss_q.size() != 0);
`endif
            gap = 0;
         end
         if (!transfer) gap++;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexp", 32'(rsp_valid), 32'd0);
            end else begin
               cmd_t e;
               e = exp_q.pop_front();
               check("rsp", {22'd0, rsp_rw, rsp_rdata, rsp_err}, {22'd0, e.rw, e.rd, e.err});
            end
         end
         prev_tr = transfer;
      end
   end

   initial begin
      int n;
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; err_clear = 1'b0;

      // Reset state
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_presetn", 32'(PRESETn), 32'd0);
      check("rst_outs", {transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr},
            32'd0);
      check("rst_misc", {cmd_ready, cmd_level, rsp_valid, rsp_rw, rsp_rdata, rsp_err, halted},
            32'd0);
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      check("presetn_rel", 32'(PRESETn), 32'd1);
      check("ready_rel", 32'(cmd_ready), 32'd1);

      // Single write with latency measurement: the push edge counts as the
      // first of XFER_CYCLES+2 edges, so rsp_valid shows XFER_CYCLES+1 later.
      push_cmd(1'b0, 9'h005, 8'hA5);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge PCLK); #1;
         n++;
      end
      check("latency", n, XFER_CYCLES + 1);
      drain();

      // Single read
      push_cmd(1'b1, 9'h1FF, 8'h00);
      drain();
      check("idle_fields", {READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data}, 32'd0);

      // Back-to-back until full
      full_seen = 0;
      for (int i = 0; i < 14; i++) begin
         push_cmd(i[0], 9'($urandom_range(0, 511)) & 9'h1F7, 8'($urandom));
      end
      drain();
      check("full_seen", 32'(full_seen != 0), 32'd1);

      // Error read followed by two writes
      push_cmd(1'b1, c_ERR_ADDR, 8'h00);
      push_cmd(1'b0, 9'h011, 8'h22);
      push_cmd(1'b0, 9'h033, 8'h44);
      n = 0;
      while (!(rsp_valid && rsp_err) && n < 50) begin
         @(posedge PCLK); #1;
         n++;
      end
      check("err_rsp_seen", 32'(rsp_valid && rsp_err), 32'd1);
      @(posedge PCLK); #1;
`ifdef APB_ERR_HALT_EN
      check("halted_set", 32'(halted), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("halt_no_xfer", 32'(transfer), 32'd0);
         @(posedge PCLK); #1;
      end
      check("halt_level", 32'(cmd_level), 32'd2);
      err_clear = 1'b1;
      @(posedge PCLK); #1;
      err_clear = 1'b0;
      check("halted_clr", 32'(halted), 32'd0);
`else
      check("halted_tied", 32'(halted), 32'd0);
      check("no_halt_xfer", 32'(transfer), 32'd1);
`endif
      drain();

      // Reset in the second transfer cycle of a command with three queued
      for (int i = 0; i < 5; i++) push_cmd(1'b0, 9'(9'h040 + i), 8'(i));
      n = 0;
      while (transfer && n < 20) begin @(posedge PCLK); #1; n++; end
      while (!transfer && n < 40) begin @(posedge PCLK); #1; n++; end
      @(posedge PCLK); #1;
      check("mid_level", 32'(cmd_level), 32'd3);
      check("mid_xfer", 32'(transfer), 32'd1);
      PRESET = 1'b1;
      exp_q.delete();
      iss_q.delete();
      @(posedge PCLK); #1;
      check("abort_xfer", 32'(transfer), 32'd0);
      check("abort_level", 32'(cmd_level), 32'd0);
      check("abort_presetn", 32'(PRESETn), 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      repeat (20) @(posedge PCLK);
      #1;
      check("post_ready", 32'(cmd_ready), 32'd1);
      check("post_idle", 32'(transfer), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
